alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between two requesters (r0, r1) in the execute stage, e.g. the main integer path and an address/branch helper. Each requester uses a valid/ready request channel and a valid/ready response channel. The arbiter picks one request per cycle and drives that request's operands and opcode onto the ALU. It captures the ALU result into that requester's response register, so results appear with one cycle of latency.

## Interface
- `XLEN`, default 32: operand/result width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rN_req_valid`  in  1: request N present (N = 0, 1).
- `rN_req_ready`  out  1: request N accepted this cycle.
- `rN_op1`, `rN_op2`  in  XLEN: request N operands.
- `rN_alu_op`  in  3: request N funct3-style opcode.
- `rN_alu_op_ext`  in  7: request N funct7-style extension.
- `rN_resp_valid`  out  1: result N held.
- `rN_resp_ready`  in  1: requester N consumes the result.
- `rN_res`  out  XLEN: result N.
- `alu_op1`, `alu_op2`  out  XLEN: to the ALU.
- `alu_op`  out  3: to the ALU.
- `alu_op_ext`  out  7: to the ALU.
- `alu_res`  in  XLEN: combinational ALU result.

## Operation
- **Eligibility:** `elig_N = rN_req_valid && (!rN_resp_valid || rN_resp_ready)`. The response slot must be free, or draining this cycle.
- **Grant:** at most one grant per cycle, decided combinationally from `elig_0`, `elig_1` and the `last` pointer.
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that is not `last`.
- **Ready:** `rN_req_ready = grant_N`.
- **ALU drive:**
  - The ALU ports carry the granted request's fields.
  - With no grant, all ALU ports are 0 (ALU_op 000, ext 0, i.e. ADD 0+0).
- **Handshake (`grant_N`):** at the next edge:
  - `rN_res <= alu_res`
  - `rN_resp_valid <= 1`
  - `last <= N`
- **Drain:** `rN_resp_valid && rN_resp_ready` without a new grant to N → `rN_resp_valid <= 0`. `rN_res` holds its value.
- **Drain and refill in the same cycle:** a new grant wins; valid stays 1 and `rN_res` is replaced.
- **Stability:** `rN_res` is stable while `rN_resp_valid=1` and `rN_resp_ready=0`.
- **Request fields:** must stay stable while `rN_req_valid=1` and `rN_req_ready=0`. The arbiter does not latch operands.
- **Width rules:** results are passed through unmodified at XLEN bits. The arbiter does no arithmetic.

## Timing
- **Reset values:**
  - `rN_resp_valid=0`, `rN_res=0`.
  - `last=1`, so r0 wins the first tie.
  - ALU ports at 0 (no grant during reset).
  - `rN_req_ready=0` while `rst=1`.
- **Latency:** request accepted in cycle T → `rN_resp_valid=1` with the result in cycle T+1.
- **Throughput:** 1 result/cycle total. A single requester that keeps `resp_ready=1` and has no contender gets back-to-back grants.
- **Contention:** under continuous contention (both eligible every cycle), grants alternate r0, r1, r0, …
- **Backpressure:** a stalled response (`resp_valid=1`, `resp_ready=0`) makes that requester ineligible. The other requester is granted in that cycle.
- **Reset mid-operation:** held results are discarded and `last` returns to 1. A request pending during reset must be re-presented, and is granted in the first cycle after `rst` deasserts.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break using `last`, as above.
- `ALU_ARB_RR_EN` undefined: fixed priority, r0 always wins ties.
  - The `last` register is omitted.
  - r1 can starve under continuous r0 traffic; this is accepted for the single-user configuration.
- All other behaviour is identical in both configurations.

## Test plan
- **Single request:** r0 ADD (op 000, ext 0) op1=5, op2=3, r0_resp_ready=1 → r0_req_ready=1 same cycle; r0_resp_valid=1, r0_res=8 next cycle; r1 outputs unchanged.
- **Tie after reset:** same cycle, r0 ADD 1+2 and r1 SUB (op 000, ext 0100000) 10−4 → r0 granted first (r0_res=3 at T+1); r1 granted at T+1 (r1_res=6 at T+2).
- **Backpressure:** r0 holds a result with r0_resp_ready=0 and presents XOR 0xF0^0xFF; r1 presents OR 0x1|0x2 → r1 granted (r1_res=3); r0_req_ready=0 until r0_resp_ready=1; then r0_res=0x0F the cycle after the grant.
- **Continuous contention:** both requesters valid for 6 cycles, responses always ready → grant order r0, r1, r0, r1, r0, r1 with `ALU_ARB_RR_EN`; r0 ×6 without it.
- **Reset mid-operation:** grant r1 SLTU 1<2, assert `rst` in the result cycle → r1_resp_valid=0, r1_res=0 after the edge; next tie goes to r0.
- **Idle:** no requests → ALU ports all 0, no resp_valid changes, held results unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters; results are registered per requester (1-cycle latency).
// Tie-break is round-robin when ALU_ARB_RR_EN is defined, otherwise fixed priority to r0.
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_req_valid,
  output logic            r0_req_ready,
  input  logic [XLEN-1:0] r0_op1,
  input  logic [XLEN-1:0] r0_op2,
  input  logic [2:0]      r0_alu_op,
  input  logic [6:0]      r0_alu_op_ext,
  output logic            r0_resp_valid,
  input  logic            r0_resp_ready,
  output logic [XLEN-1:0] r0_res,
  input  logic            r1_req_valid,
  output logic            r1_req_ready,
  input  logic [XLEN-1:0] r1_op1,
  input  logic [XLEN-1:0] r1_op2,
  input  logic [2:0]      r1_alu_op,
  input  logic [6:0]      r1_alu_op_ext,
  output logic            r1_resp_valid,
  input  logic            r1_resp_ready,
  output logic [XLEN-1:0] r1_res,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_op,
  output logic [6:0]      alu_op_ext,
  input  logic [XLEN-1:0] alu_res
);

  logic elig0, elig1;
  logic grant0, grant1;

`ifdef ALU_ARB_RR_EN
  logic last;
`endif

  always_comb begin
    // A response slot that drains this cycle can accept a new result.
    elig0 = r0_req_valid && (!r0_resp_valid || r0_resp_ready);
    elig1 = r1_req_valid && (!r1_resp_valid || r1_resp_ready);
`ifdef ALU_ARB_RR_EN
    grant0 = !rst && elig0 && (!elig1 || last);
    grant1 = !rst && elig1 && (!elig0 || !last);
`else
    grant0 = !rst && elig0;
    grant1 = !rst && elig1 && !elig0;
`endif
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_op     = '0;
    alu_op_ext = '0;
    if (grant0) begin
      alu_op1    = r0_op1;
      alu_op2    = r0_op2;
      alu_op     = r0_alu_op;
      alu_op_ext = r0_alu_op_ext;
    end else if (grant1) begin
      alu_op1    = r1_op1;
      alu_op2    = r1_op2;
      alu_op     = r1_alu_op;
      alu_op_ext = r1_alu_op_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_resp_valid <= 1'b0;
      r0_res        <= '0;
      r1_resp_valid <= 1'b0;
      r1_res        <= '0;
    end else begin
      // A new grant takes precedence over a same-cycle drain.
      if (grant0) begin
        r0_res        <= alu_res;
        r0_resp_valid <= 1'b1;
      end else if (r0_resp_ready) begin
        r0_resp_valid <= 1'b0;
      end
      if (grant1) begin
        r1_res        <= alu_res;
        r1_resp_valid <= 1'b1;
      end else if (r1_resp_ready) begin
        r1_resp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant0) begin
      last <= 1'b0;
    end else if (grant1) begin
      last <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
  logic [XLEN-1:0] r0_op1, r0_op2, r0_res;
  logic [2:0]      r0_alu_op;
  logic [6:0]      r0_alu_op_ext;
  logic            r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
  logic [XLEN-1:0] r1_op1, r1_op2, r1_res;
  logic [2:0]      r1_alu_op;
  logic [6:0]      r1_alu_op_ext;
  logic [XLEN-1:0] alu_op1, alu_op2, alu_res;
  logic [2:0]      alu_op;
  logic [6:0]      alu_op_ext;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_alu_op(r0_alu_op), .r0_alu_op_ext(r0_alu_op_ext),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_res(r0_res),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_alu_op(r1_alu_op), .r1_alu_op_ext(r1_alu_op_ext),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_res(r1_res),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_op_ext(alu_op_ext),
    .alu_res(alu_res)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000:  alu_res = (alu_op_ext == 7'b0100000) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
      3'b011:  alu_res = {31'd0, alu_op1 < alu_op2};
      3'b100:  alu_res = alu_op1 ^ alu_op2;
      3'b110:  alu_res = alu_op1 | alu_op2;
      3'b111:  alu_res = alu_op1 & alu_op2;
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0_req_valid = 0; r0_op1 = 0; r0_op2 = 0; r0_alu_op = 0; r0_alu_op_ext = 0; r0_resp_ready = 1;
    r1_req_valid = 0; r1_op1 = 0; r1_op2 = 0; r1_alu_op = 0; r1_alu_op_ext = 0; r1_resp_ready = 1;

    // Reset: a pending request is refused and the ALU sees zeros.
    @(negedge clk);
    r0_req_valid = 1; r0_op1 = 5; r0_op2 = 3;
    #1;
    chk("rst_r0_ready", {31'd0, r0_req_ready}, 0);
    chk("rst_alu_op1", alu_op1, 0);
    after_edge();
    chk("rst_r0_vld", {31'd0, r0_resp_valid}, 0);
    chk("rst_r0_res", r0_res, 0);
    chk("rst_r1_vld", {31'd0, r1_resp_valid}, 0);

    // Single request, granted in the first cycle after reset.
    @(negedge clk);
    rst = 0;
    #1;
    chk("single_r0_ready", {31'd0, r0_req_ready}, 1);
    chk("single_r1_ready", {31'd0, r1_req_ready}, 0);
    chk("single_alu_op1", alu_op1, 5);
    chk("single_alu_op2", alu_op2, 3);
    after_edge();
    chk("single_r0_vld", {31'd0, r0_resp_valid}, 1);
    chk("single_r0_res", r0_res, 8);
    chk("single_r1_vld", {31'd0, r1_resp_valid}, 0);
    chk("single_r1_res", r1_res, 0);

    // Tie after reset: r0 first, then r1.
    @(negedge clk);
    r0_req_valid = 0;
    do_reset();
    r0_req_valid = 1; r0_op1 = 1; r0_op2 = 2; r0_alu_op = 0; r0_alu_op_ext = 0;
    r1_req_valid = 1; r1_op1 = 10; r1_op2 = 4; r1_alu_op = 0; r1_alu_op_ext = 7'b0100000;
    #1;
    chk("tie_r0_ready", {31'd0, r0_req_ready}, 1);
    chk("tie_r1_ready", {31'd0, r1_req_ready}, 0);
    after_edge();
    chk("tie_r0_res", r0_res, 3);
    @(negedge clk);
    r0_req_valid = 0;
    #1;
    chk("tie_r1_ready2", {31'd0, r1_req_ready}, 1);
    chk("tie_alu_ext", {25'd0, alu_op_ext}, 32'h20);
    after_edge();
    chk("tie_r1_res", r1_res, 6);
    chk("tie_r1_vld", {31'd0, r1_resp_valid}, 1);
    chk("tie_r0_drained", {31'd0, r0_resp_valid}, 0);
    chk("tie_r0_hold", r0_res, 3);

    // Backpressure: r0 holds 7 with resp_ready low; r1 gets the ALU.
    @(negedge clk);
    r1_req_valid = 0;
    r0_req_valid = 1; r0_op1 = 7; r0_op2 = 0; r0_resp_ready = 0;
    after_edge();
    chk("bp_r0_hold_res", r0_res, 7);
    @(negedge clk);
    r0_op1 = 32'hF0; r0_op2 = 32'hFF; r0_alu_op = 3'b100;
    r1_req_valid = 1; r1_op1 = 1; r1_op2 = 2; r1_alu_op = 3'b110; r1_alu_op_ext = 0;
    #1;
    chk("bp_r0_ready", {31'd0, r0_req_ready}, 0);
    chk("bp_r1_ready", {31'd0, r1_req_ready}, 1);
    chk("bp_alu_op", {29'd0, alu_op}, 6);
    after_edge();
    chk("bp_r1_res", r1_res, 3);
    chk("bp_r0_stable", r0_res, 7);
    chk("bp_r0_vld", {31'd0, r0_resp_valid}, 1);
    @(negedge clk);
    r1_req_valid = 0;
    #1;
    chk("bp_r0_still_blocked", {31'd0, r0_req_ready}, 0);
    chk("bp_idle_alu_op1", alu_op1, 0);
    after_edge();
    chk("bp_r0_stable2", r0_res, 7);
    @(negedge clk);
    r0_resp_ready = 1;
    #1;
    chk("bp_r0_refill_ready", {31'd0, r0_req_ready}, 1);
    chk("bp_alu_op_xor", {29'd0, alu_op}, 4);
    after_edge();
    chk("bp_r0_res_xor", r0_res, 32'h0F);
    chk("bp_r0_vld2", {31'd0, r0_resp_valid}, 1);

    // Idle: nothing requested, held result stays put.
    @(negedge clk);
    r0_req_valid = 0; r0_resp_ready = 0;
    #1;
    chk("idle_alu_op1", alu_op1, 0);
    chk("idle_alu_op2", alu_op2, 0);
    chk("idle_alu_op", {29'd0, alu_op}, 0);
    chk("idle_alu_ext", {25'd0, alu_op_ext}, 0);
    after_edge();
    after_edge();
    chk("idle_r0_vld", {31'd0, r0_resp_valid}, 1);
    chk("idle_r0_res", r0_res, 32'h0F);
    chk("idle_r1_vld", {31'd0, r1_resp_valid}, 0);
    chk("idle_r1_res", r1_res, 3);

    // Continuous contention for six cycles.
    @(negedge clk);
    r0_resp_ready = 1;
    do_reset();
    r0_req_valid = 1; r0_alu_op = 0; r0_alu_op_ext = 0; r0_op1 = 100; r0_op2 = 0;
    r1_req_valid = 1; r1_alu_op = 0; r1_alu_op_ext = 0; r1_op1 = 200; r1_op2 = 0;
    for (int i = 0; i < 6; i++) begin
      logic exp0;
`ifdef ALU_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      chk($sformatf("cont%0d_r0_ready", i), {31'd0, r0_req_ready}, {31'd0, exp0});
      chk($sformatf("cont%0d_r1_ready", i), {31'd0, r1_req_ready}, {31'd0, !exp0});
      @(negedge clk);
    end
    r0_req_valid = 0; r1_req_valid = 0;

    // Reset in the result cycle of an r1 SLTU.
    r1_req_valid = 1; r1_op1 = 1; r1_op2 = 2; r1_alu_op = 3'b011; r1_alu_op_ext = 0;
    after_edge();
    chk("mid_r1_res", r1_res, 1);
    @(negedge clk);
    rst = 1; r1_req_valid = 0; r1_resp_ready = 0;
    after_edge();
    chk("mid_r1_vld", {31'd0, r1_resp_valid}, 0);
    chk("mid_r1_res_clr", r1_res, 0);
    @(negedge clk);
    r1_resp_ready = 1;
    r0_req_valid = 1; r0_op1 = 9; r0_op2 = 1; r0_alu_op = 0;
    r1_req_valid = 1; r1_op1 = 4; r1_op2 = 4; r1_alu_op = 0;
    #1;
    chk("mid_rst_r0_ready", {31'd0, r0_req_ready}, 0);
    chk("mid_rst_r1_ready", {31'd0, r1_req_ready}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_tie_r0_ready", {31'd0, r0_req_ready}, 1);
    chk("mid_tie_r1_ready", {31'd0, r1_req_ready}, 0);
    after_edge();
    chk("mid_tie_r0_res", r0_res, 10);
    @(negedge clk);
    r0_req_valid = 0; r1_req_valid = 0;
    after_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
